// File: rtl/dot_pkg.sv
// Shared constants, FSM encoding and the 4x4 nibble-product table for serial_dot_rx.
package dot_pkg;

    localparam int ELEM_W     = 8;
    localparam int N_ELEM     = 8;
    localparam int VEC_W      = N_ELEM * ELEM_W;
    localparam int FRAME_BITS = 2 * VEC_W;
    localparam int OUT_W      = 2 * ELEM_W + $clog2(N_ELEM);
    localparam int CNT_W      = $clog2(FRAME_BITS);
    localparam int IDX_W      = $clog2(N_ELEM);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_MAC,
        ST_DONE
    } state_e;

    // Entry {a,b} holds a*b for two 4-bit operands, 8 bits per entry.
    function automatic logic [2047:0] build_nib_tbl();
        logic [2047:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                t[(i * 16 + j) * 8 +: 8] = 8'(i * j);
            end
        end
        return t;
    endfunction

    localparam logic [2047:0] NIB_TBL = build_nib_tbl();

    function automatic logic [7:0] nib_mul(input logic [3:0] a, input logic [3:0] b);
        return NIB_TBL[int'({a, b}) * 8 +: 8];
    endfunction

endpackage

// File: rtl/dot_mult8.sv
// Combinational 8x8 -> 16 unsigned multiplier; zero latency, no backpressure.
// DOT_LUT_MULT_EN selects the nibble-table implementation instead of '*'.
module dot_mult8
    import dot_pkg::*;
(
    input  logic [ELEM_W-1:0]   a_i,
    input  logic [ELEM_W-1:0]   b_i,
    output logic [2*ELEM_W-1:0] p_o
);

`ifdef DOT_LUT_MULT_EN
    logic [7:0] pp_ll;
    logic [7:0] pp_lh;
    logic [7:0] pp_hl;
    logic [7:0] pp_hh;

    // Four nibble partials recombined by weight: hh<<8, cross terms <<4, ll<<0.
    always_comb begin
        pp_ll = nib_mul(a_i[3:0], b_i[3:0]);
        pp_lh = nib_mul(a_i[3:0], b_i[7:4]);
        pp_hl = nib_mul(a_i[7:4], b_i[3:0]);
        pp_hh = nib_mul(a_i[7:4], b_i[7:4]);
        p_o   = {pp_hh, 8'h00}
              + {4'h0, pp_lh, 4'h0}
              + {4'h0, pp_hl, 4'h0}
              + {8'h00, pp_ll};
    end
`else
    always_comb begin
        p_o = (2*ELEM_W)'(a_i) * (2*ELEM_W)'(b_i);
    end
`endif

endmodule

// File: rtl/serial_dot_rx.sv
// Serial-in dot product: 128 frame bits LSB first, then one MAC per element (build option DOT_LUT_MULT_EN).
// Latency: Done high 136 edges after the Start-sampling edge; no backpressure, input is free-running.
module serial_dot_rx
    import dot_pkg::*;
(
    input  logic             clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             SerialData,
    output logic [OUT_W-1:0] DataOut,
    output logic             Done
);

    state_e                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [FRAME_BITS-1:0]   sr_q;
    logic [OUT_W-1:0]        acc_q;
    logic [OUT_W-1:0]        acc_d;
    logic [OUT_W-1:0]        data_q;
    logic                    done_q;

    logic [ELEM_W-1:0]       a_sel;
    logic [ELEM_W-1:0]       b_sel;
    logic [2*ELEM_W-1:0]     prod;

    always_comb begin
        a_sel = sr_q[int'(idx_q) * ELEM_W +: ELEM_W];
        b_sel = sr_q[VEC_W + int'(idx_q) * ELEM_W +: ELEM_W];
        acc_d = acc_q + OUT_W'(prod);
    end

    dot_mult8 u_mult (
        .a_i (a_sel),
        .b_i (b_sel),
        .p_o (prod)
    );

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            acc_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        state_q <= ST_RECV;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                ST_RECV: begin
                    // Right shift with new bit at the MSB leaves frame bit k at sr_q[k].
                    sr_q <= {SerialData, sr_q[FRAME_BITS-1:1]};
                    if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                        state_q <= ST_MAC;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_MAC: begin
                    acc_q <= acc_d;
                    if (idx_q == IDX_W'(N_ELEM - 1)) begin
                        data_q  <= acc_d;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    if (Start) begin
                        state_q <= ST_RECV;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign DataOut = data_q;
    assign Done    = done_q;

endmodule

// File: tb/tb_serial_dot_rx.sv
// Bench for serial_dot_rx: vector table, corner-case sequences and random frames against a reference model.
module tb_serial_dot_rx;
    import dot_pkg::*;

    logic             clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Start = 1'b0;
    logic             SerialData = 1'b0;
    logic [OUT_W-1:0] DataOut;
    logic             Done;

    serial_dot_rx dut (
        .clk        (clk),
        .Reset      (Reset),
        .Start      (Start),
        .SerialData (SerialData),
        .DataOut    (DataOut),
        .Done       (Done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [OUT_W-1:0] val;
        int               cyc;
    } exp_t;

    typedef struct {
        logic [63:0]      a;
        logic [63:0]      b;
        logic [OUT_W-1:0] res;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    int   last_done_cyc = 0;
    int   prev_done_cyc = 0;

    localparam logic [63:0] A1 = 64'h123456789abcdef0;
    localparam logic [63:0] B1 = 64'hfedcba9876543210;

    function automatic logic [OUT_W-1:0] ref_dot(input logic [63:0] a, input logic [63:0] b);
        logic [OUT_W-1:0] s;
        s = '0;
        for (int i = 0; i < N_ELEM; i++) begin
            s = s + OUT_W'(16'(a[i*8 +: 8]) * 16'(b[i*8 +: 8]));
        end
        return s;
    endfunction

    task automatic chk(input string name, input longint got, input longint req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // Called on a falling edge; Start is sampled at the next rising edge.
    task automatic start_frame(input logic [OUT_W-1:0] ev, input bit push);
        exp_t e;
        Start = 1'b1;
        if (push) begin
            e.val = ev;
            e.cyc = cyc + 137;
            sb.push_back(e);
        end
        @(negedge clk);
        Start = 1'b0;
    endtask

    task automatic shift_bits(input logic [127:0] f, input int from, input int to, input int glitch);
        for (int k = from; k <= to; k++) begin
            SerialData = f[k];
            Start      = (k == glitch);
            @(negedge clk);
        end
        Start = 1'b0;
    endtask

    // Returns on the falling edge where Done is visible, so a following call is back-to-back.
    task automatic run_frame(input logic [63:0] a, input logic [63:0] b, input logic [OUT_W-1:0] ev,
                             input int glitch, input int mac_glitch);
        start_frame(ev, 1'b1);
        shift_bits({b, a}, 0, 127, glitch);
        for (int k = 0; k < 8; k++) begin
            SerialData = 1'($urandom);
            Start      = (k == mac_glitch);
            @(negedge clk);
        end
        Start = 1'b0;
    endtask

    // Scoreboard: every Done must match the oldest pending frame in value and cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (Done) begin
                done_cnt++;
                prev_done_cyc = last_done_cyc;
                last_done_cyc = cyc;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done cyc=%0d DataOut=%h required no Done", cyc, DataOut);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (DataOut !== e.val || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL result got=%h at cyc %0d required=%h at cyc %0d",
                                 DataOut, cyc, e.val, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        vec_t tbl[7];
        int   d0;
        int   n_before;

        tbl[0] = '{A1, B1, 19'h18350};
        tbl[1] = '{64'hffffffffffffffff, 64'hffffffffffffffff, 19'h7F008};
        tbl[2] = '{64'hffffffffffffffff, 64'h0, 19'h0};
        tbl[3] = '{64'h0101010101010101, 64'h0202020202020202, 19'h10};
        tbl[4] = '{64'h00000000000000ff, 64'h00000000000000ff, 19'h0FE01};
        tbl[5] = '{64'hff00000000000000, 64'hff00000000000000, 19'h0FE01};
        tbl[6] = '{64'h0102030405060708, 64'h0101010101010101, 19'h24};

        Reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_dataout", DataOut, 0);
        chk("reset_done", Done, 0);
        Reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_done", Done, 0);

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].a, tbl[i].b, tbl[i].res, -1, -1);
            repeat (4) @(negedge clk);
            chk("hold_dataout", DataOut, tbl[i].res);
        end

        // Start pulses during RECV and MAC must be ignored.
        d0 = done_cnt;
        run_frame(A1, B1, 19'h18350, 40, 3);
        repeat (4) @(negedge clk);
        chk("glitch_done_count", done_cnt - d0, 1);

        // Reset at bit 70 aborts the frame with no Done.
        n_before = done_cnt;
        start_frame('0, 1'b0);
        shift_bits({B1, A1}, 0, 69, -1);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        chk("abort_dataout", DataOut, 0);
        chk("abort_done", Done, 0);
        repeat (200) @(negedge clk);
        chk("abort_no_done", done_cnt - n_before, 0);
        run_frame(A1, B1, 19'h18350, -1, -1);
        repeat (2) @(negedge clk);

        // Back-to-back: second Start sampled in the Done cycle.
        d0 = done_cnt;
        run_frame(A1, B1, 19'h18350, -1, -1);
        run_frame(64'h0101010101010101, 64'h0202020202020202, 19'h10, -1, -1);
        repeat (3) @(negedge clk);
        chk("b2b_count", done_cnt - d0, 2);
        chk("b2b_gap", last_done_cyc - prev_done_cyc, 137);
        chk("b2b_hold", DataOut, 19'h10);

        for (int n = 0; n < 300; n++) begin
            logic [63:0] ra;
            logic [63:0] rb;
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if (n % 50 == 0) rb = 64'hffffffffffffffff;
            run_frame(ra, rb, ref_dot(ra, rb), -1, -1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
